// File: rtl/softmax_bwd_seq_pkg.sv
// Shared widths, state encoding and Q-format types for the softmax backward engine.
package softmax_pkg;

    localparam int LEN_DEF   = 8;
    localparam int Y_W_DEF   = 16;
    localparam int G_W_DEF   = 16;
    localparam int OUT_W_DEF = 16;

    function automatic int acc_w(input int y_w, input int g_w, input int len);
        return y_w + g_w + 1 + $clog2(len);
    endfunction

    function automatic int s_w(input int g_w, input int len);
        return g_w + 1 + $clog2(len);
    endfunction

    typedef enum logic [1:0] {LOAD, CALC, PRIME, EMIT} sm_bwd_state_t;

    typedef logic        [Y_W_DEF-1:0] prob_t;  // unsigned Q0.16
    typedef logic signed [G_W_DEF-1:0] grad_t;  // signed Q8.8

endpackage

// File: rtl/softmax_bwd_seq_if.sv
// Input (y, g) stream and output dx stream of the softmax backward engine.
interface softmax_bwd_seq_if #(
    parameter int Y_W   = 16,
    parameter int G_W   = 16,
    parameter int OUT_W = 16
);
    // Both streams: a beat transfers on a rising clk edge where valid && ready;
    // the source holds valid and data stable until that edge, ready never waits on valid.
    logic                    in_valid;
    logic                    in_ready;
    logic        [Y_W-1:0]   in_y;
    logic signed [G_W-1:0]   in_g;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_dx;
    logic                    out_last;

    modport slave (
        input  in_valid, in_y, in_g, out_ready,
        output in_ready, out_valid, out_dx, out_last
    );

    modport master (
        output in_valid, in_y, in_g, out_ready,
        input  in_ready, out_valid, out_dx, out_last
    );

endinterface

// File: rtl/softmax_bwd_seq_scale.sv
// dx = (y * diff) >>> Y_W reduced to OUT_W bits.
// SOFTMAX_BWD_SAT_EN selects saturation; otherwise the result wraps.
module softmax_bwd_scale
    import softmax_pkg::*;
#(
    parameter int Y_W   = Y_W_DEF,
    parameter int S_W   = 20,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic        [Y_W-1:0]   i_y,
    input  logic signed [S_W:0]     i_diff,
    output logic signed [OUT_W-1:0] o_dx
);

    localparam int P_W = Y_W + S_W + 2;

    logic signed [P_W-1:0] w_prod;

    assign w_prod = P_W'($signed({1'b0, i_y})) * P_W'(i_diff);

`ifdef SOFTMAX_BWD_SAT_EN
    localparam logic signed [P_W-1:0] MAX_V = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] MIN_V = {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [P_W-1:0] w_full;

    assign w_full = w_prod >>> Y_W;

    always_comb begin
        o_dx = w_full[OUT_W-1:0];
        if (w_full > MAX_V) begin
            o_dx = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_full < MIN_V) begin
            o_dx = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end
`else
    assign o_dx = OUT_W'(w_prod >>> Y_W);
`endif

endmodule

// File: rtl/softmax_bwd_seq.sv
// Streaming softmax backward: buffers LEN (y, g) beats, forms s = sum y*g, emits dx_i = y_i*(g_i - s).
// Optional build macro SOFTMAX_BWD_SAT_EN saturates dx instead of wrapping.
module softmax_bwd_seq
    import softmax_pkg::*;
#(
    parameter int LEN   = LEN_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int G_W   = G_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    softmax_bwd_seq_if.slave bus,
    output logic          busy,
    output sm_bwd_state_t o_dbg_state
);

    localparam int ACC_W  = acc_w(Y_W, G_W, LEN);
    localparam int S_W    = s_w(G_W, LEN);
    localparam int PROD_W = Y_W + G_W + 1;
    localparam int IDX_W  = $clog2(LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    sm_bwd_state_t r_state;
    sm_bwd_state_t w_next_state;

    logic        [IDX_W-1:0]  r_idx;
    logic        [IDX_W-1:0]  w_sel_idx;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [S_W-1:0]    r_s;
    logic        [Y_W-1:0]    r_y [LEN];
    logic signed [G_W-1:0]    r_g [LEN];
    logic signed [OUT_W-1:0]  r_dx;
    logic signed [OUT_W-1:0]  w_dx;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_idx_last;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [S_W:0]      w_diff;

    assign w_in_fire  = bus.in_valid && (r_state == LOAD);
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_idx_last = (r_idx == LAST_IDX);
    assign w_prod     = PROD_W'($signed({1'b0, bus.in_y})) * PROD_W'(bus.in_g);

    // PRIME computes element 0 (idx is 0 there); EMIT precomputes the element after the one on the bus.
    assign w_sel_idx = (r_state == EMIT && !w_idx_last) ? r_idx + IDX_W'(1) : r_idx;
    assign w_diff    = (S_W+1)'(r_g[w_sel_idx]) - (S_W+1)'(r_s);

    softmax_bwd_scale #(
        .Y_W   (Y_W),
        .S_W   (S_W),
        .OUT_W (OUT_W)
    ) u_scale (
        .i_y    (r_y[w_sel_idx]),
        .i_diff (w_diff),
        .o_dx   (w_dx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_in_fire && w_idx_last) w_next_state = CALC;
            CALC:    w_next_state = PRIME;
            PRIME:   w_next_state = EMIT;
            EMIT:    if (w_out_fire && w_idx_last) w_next_state = LOAD;
            default: w_next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_s         <= '0;
            r_dx        <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_acc <= r_acc + ACC_W'(w_prod);
                        r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
                    end
                end
                CALC: begin
                    r_s <= S_W'(r_acc >>> Y_W);
                end
                PRIME: begin
                    r_dx        <= w_dx;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (LEN == 1);
                end
                EMIT: begin
                    if (w_out_fire) begin
                        if (w_idx_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_acc       <= '0;
                            r_idx       <= '0;
                        end else begin
                            r_idx      <= w_sel_idx;
                            r_dx       <= w_dx;
                            r_out_last <= (w_sel_idx == LAST_IDX);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The element buffer is fully rewritten before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_y[r_idx] <= bus.in_y;
            r_g[r_idx] <= bus.in_g;
        end
    end

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = r_out_valid;
    assign bus.out_dx    = r_dx;
    assign bus.out_last  = r_out_last;
    assign busy          = !((r_state == LOAD) && (r_idx == '0));
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_softmax_bwd_seq.sv
// Self-checking bench for softmax_bwd_seq against a plain-arithmetic reference model.
module tb_softmax_bwd_seq;
  import softmax_pkg::*;

  localparam int LEN = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  softmax_bwd_seq_if #(.Y_W(16), .G_W(16), .OUT_W(16)) bus ();
  logic          busy;
  sm_bwd_state_t dbg_state;

  softmax_bwd_seq #(.LEN(LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [16:0] exp_q[$];  // {last, dx}

  function automatic void model_push(input logic [15:0] y[LEN], input logic [15:0] g[LEN]);
    longint s;
    longint d;
    logic [15:0] r;
    s = 0;
    for (int j = 0; j < LEN; j++) s += longint'(y[j]) * longint'($signed(g[j]));
    s = s >>> 16;
    for (int i = 0; i < LEN; i++) begin
      d = longint'(y[i]) * (longint'($signed(g[i])) - s);
      d = d >>> 16;
`ifdef SOFTMAX_BWD_SAT_EN
      if (d > 32767) r = 16'h7fff;
      else if (d < -32768) r = 16'h8000;
      else r = d[15:0];
`else
      r = d[15:0];
`endif
      exp_q.push_back({(i == LEN - 1), r});
    end
  endfunction

  // ---------------- input driver ----------------
  int last_hs_cyc = 0;

  task automatic drive_vector(input logic [15:0] y[LEN], input logic [15:0] g[LEN],
                              input int n_beats, input bit gaps, input bit hold_valid);
    int  w;
    bit  ok;
    for (int i = 0; i < n_beats; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_y     = y[i];
      bus.in_g     = g[i];
      w  = 0;
      ok = 1'b0;
      while (!ok && w < 100) begin
        ok = bus.in_ready;
        @(negedge clk);
        w++;
      end
      if (!ok) check_val("in_hs_timeout", 64'd0, 64'd1);
    end
    last_hs_cyc = cyc;
    if (!hold_valid) bus.in_valid = 1'b0;
    if (n_beats == LEN) model_push(y, g);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check_val("drain", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    check_val("idle_state", dbg_state, LOAD);
    check_val("idle_busy", busy, 0);
  endtask

  // ---------------- output monitor ----------------
  bit          mon_rand   = 1'b0;
  int          stall_at   = -1;
  int          stall_left = 0;

  initial begin
    int          beat;
    bit          prev_valid;
    bit          prev_ready;
    bit          rdy;
    logic [15:0] held_dx;
    logic        held_last;
    logic [16:0] e;
    beat = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    held_dx = '0;
    held_last = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        beat = 0;
        continue;
      end
      if (bus.out_valid && !prev_valid) check_val("latency", cyc - last_hs_cyc, 2);
      if (bus.out_valid && prev_valid && !prev_ready) begin
        check_val("hold_dx", $unsigned(bus.out_dx), held_dx);
        check_val("hold_last", bus.out_last, held_last);
      end
      rdy = 1'b1;
      if (bus.out_valid && beat == stall_at && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        check_val("in_ready_emit", bus.in_ready, 0);
      end else if (mon_rand) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("dx", $unsigned(bus.out_dx), e[15:0]);
          check_val("last", bus.out_last, e[16]);
        end
        beat = (beat == LEN - 1) ? 0 : beat + 1;
      end
      prev_valid = bus.out_valid;
      prev_ready = rdy;
      held_dx    = bus.out_dx;
      held_last  = bus.out_last;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] y[LEN];
    logic [15:0] g[LEN];
    bit          hist[$];
    logic [17:0] o_pat;
    logic [17:0] x_pat;

    bus.in_valid = 1'b0;
    bus.in_y     = '0;
    bus.in_g     = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_state", dbg_state, LOAD);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_dx", $unsigned(bus.out_dx), 0);
    check_val("rst_out_last", bus.out_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // uniform vector: s equals g, every dx is zero
    for (int i = 0; i < LEN; i++) begin y[i] = 16'h2000; g[i] = 16'h0100; end
    drive_vector(y, g, LEN, 1'b0, 1'b0);
    wait_drain();

    // two-hot y
    for (int i = 0; i < LEN; i++) begin
      y[i] = (i < 2) ? 16'h8000 : 16'h0000;
      g[i] = (i == 0) ? 16'h0200 : (i == 1) ? 16'h0000 : 16'h0100;
    end
    drive_vector(y, g, LEN, 1'b0, 1'b0);
    wait_drain();

    // same vector with a 3-cycle stall at beat 3
    stall_at   = 3;
    stall_left = 3;
    drive_vector(y, g, LEN, 1'b0, 1'b0);
    wait_drain();
    check_val("stall_used", stall_left, 0);
    stall_at = -1;

    // overflow of dx beyond the output range
    for (int i = 0; i < LEN; i++) begin
      y[i] = 16'hffff;
      g[i] = (i == 0) ? 16'h7fff : 16'h8000;
    end
    drive_vector(y, g, LEN, 1'b0, 1'b0);
    wait_drain();

    // async reset mid-vector
    for (int i = 0; i < LEN; i++) begin
      y[i] = 16'($urandom_range(0, 65535));
      g[i] = 16'($urandom_range(0, 65535));
    end
    drive_vector(y, g, 5, 1'b0, 1'b0);
    check_val("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_state", dbg_state, LOAD);
    check_val("arst_out_valid", bus.out_valid, 0);
    check_val("arst_out_dx", $unsigned(bus.out_dx), 0);
    check_val("arst_out_last", bus.out_last, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LEN; i++) begin y[i] = 16'h2000; g[i] = 16'h0100; end
    drive_vector(y, g, LEN, 1'b0, 1'b0);
    wait_drain();

    // back-to-back vectors, in_valid and out_ready held high
    fork
      begin
        for (int k = 0; k < 3 * (2 * LEN + 2); k++) begin
          hist.push_back(bus.in_ready);
          @(negedge clk);
        end
      end
      begin
        for (int v = 0; v < 3; v++) begin
          for (int i = 0; i < LEN; i++) begin
            y[i] = 16'($urandom_range(0, 16'h3fff));
            g[i] = 16'($urandom_range(0, 65535));
          end
          drive_vector(y, g, LEN, 1'b0, (v < 2));
        end
      end
    join
    wait_drain();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 18; i++) begin
        o_pat[i] = hist[p * 18 + i];
        x_pat[i] = (i < LEN);
      end
      check_val("rdy_pattern", o_pat, x_pat);
    end

    // randomized vectors with input gaps and random backpressure
    mon_rand = 1'b1;
    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < LEN; i++) begin
        y[i] = (v % 2 == 0) ? 16'($urandom_range(0, 16'h2000)) : 16'($urandom_range(0, 65535));
        g[i] = 16'($urandom_range(0, 65535));
      end
      drive_vector(y, g, LEN, 1'b1, 1'b0);
    end
    wait_drain();
    mon_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
